// File: rtl/sum_accumulator.sv
// sum_accumulator: collects up to N unsigned samples per block and presents
// their total, truncated average (total >> log2(N)) and sample count with a
// valid/ready handshake. A flush closes a partial block early.
module sum_accumulator #(
   parameter int unsigned W = 6,
   parameter int unsigned N = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_valid,
   input  logic [W-1:0]                  in_data,
   output logic                          in_ready,
   input  logic                          flush,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [W+$clog2(N)-1:0]        out_sum,
   output logic [W-1:0]                  out_avg,
   output logic [$clog2(N):0]            out_count
);

   localparam int unsigned CW = $clog2(N);
   localparam int unsigned SW = W + CW;
   localparam int unsigned KW = CW + 1;

   typedef enum logic {
      ACCUM = 1'b0,
      HOLD  = 1'b1
   } state_t;

   state_t          state_q;
   logic [SW-1:0]   acc_q;
   logic [KW-1:0]   cnt_q;
   logic [SW-1:0]   sum_q;
   logic [W-1:0]    avg_q;
   logic [KW-1:0]   count_q;

   logic            accept_c;
   logic            close_c;
   logic [SW-1:0]   acc_d;
   logic [KW-1:0]   cnt_d;

   // Running total including any sample accepted this cycle, and block-close decision.
   always_comb begin
      accept_c = 1'b0;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      close_c  = 1'b0;
      if (state_q == ACCUM) begin
         accept_c = in_valid;
         if (accept_c) begin
            acc_d = acc_q + SW'(in_data);
            cnt_d = cnt_q + KW'(1);
         end
         close_c = (cnt_d == KW'(N)) || (flush && (cnt_d != KW'(0)));
      end
   end

   // Block FSM: accumulate in ACCUM, latch result and hold it until consumed.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ACCUM;
         acc_q   <= '0;
         cnt_q   <= '0;
         sum_q   <= '0;
         avg_q   <= '0;
         count_q <= '0;
      end else begin
         case (state_q)
            ACCUM: begin
               if (close_c) begin
                  state_q <= HOLD;
                  sum_q   <= acc_d;
                  avg_q   <= acc_d[SW-1:CW];
                  count_q <= cnt_d;
                  acc_q   <= '0;
                  cnt_q   <= '0;
               end else begin
                  acc_q   <= acc_d;
                  cnt_q   <= cnt_d;
               end
            end
            HOLD: begin
               if (out_ready) begin
                  state_q <= ACCUM;
                  acc_q   <= '0;
                  cnt_q   <= '0;
               end
            end
            default: state_q <= ACCUM;
         endcase
      end
   end

   // Handshake flags decode directly from the state register.
   assign in_ready  = (state_q == ACCUM);
   assign out_valid = (state_q == HOLD);
   assign out_sum   = sum_q;
   assign out_avg   = avg_q;
   assign out_count = count_q;

endmodule

// File: doc/sum_accumulator.md
SUM_ACCUMULATOR -- requirements
Module: sum_accumulator

Interface
REQ-001: Parameter W, default 6, sets the input sample width in bits; this matches the adder-tree sum output.
REQ-002: Parameter N, default 4, sets the samples per block; it SHALL be a power of two, N >= 2.
REQ-003: Derived constant CW = log2(N); out_sum width SHALL be W+CW.
REQ-004: clk  input  1  clock; all state updates on the rising edge.
REQ-005: rst  input  1  reset, synchronous, active-high.
REQ-006: in_valid  input  1  in_data carries a sample this cycle.
REQ-007: in_data  input  W  unsigned sample, typically the registered sum from the upstream adder tree.
REQ-008: in_ready  output  1  block can accept a sample this cycle.
REQ-009: flush  input  1  close the current partial block early.
REQ-010: out_valid  output  1  block result is available.
REQ-011: out_ready  input  1  downstream consumes the result.
REQ-012: out_sum  output  W+CW  unsigned total of the accepted samples in the block.
REQ-013: out_avg  output  W  out_sum >> CW, truncated.
REQ-014: out_count  output  CW+1  number of samples in the block (1..N).

Function
REQ-015: The block SHALL implement a two-state FSM: ACCUM (collecting) and HOLD (presenting a result).
REQ-016: in_ready SHALL be 1 exactly when the state is ACCUM; out_valid SHALL be 1 exactly when the state is HOLD.
REQ-017: A sample SHALL be accepted when in_valid && in_ready; on acceptance, acc <= acc + in_data and cnt <= cnt + 1.
REQ-018: Addition SHALL be unsigned at width W+CW with no overflow possible; N*(2^W-1) always fits.
REQ-019: When an acceptance brings cnt to N, the next state SHALL be HOLD; out_valid rises on the following cycle (one-cycle latency from the Nth accept).
REQ-020: In ACCUM, flush with cnt > 0 (counting any sample accepted in the same cycle) SHALL move the state to HOLD with the partial total.
REQ-021: flush with cnt == 0 and no same-cycle acceptance SHALL be ignored.
REQ-022: flush in HOLD SHALL be ignored.
REQ-023: When a same-cycle sample and flush occur together, the sample SHALL be included in the result.
REQ-024: In HOLD, out_sum, out_avg and out_count SHALL be registered and stay stable until the handshake completes.
REQ-025: In HOLD, in_valid SHALL be ignored; no sample is accepted.
REQ-026: out_valid && out_ready SHALL return the state to ACCUM with acc = 0 and cnt = 0 on the next cycle.
REQ-027: No sample SHALL be accepted in the same cycle as the output handshake, because in_ready = 0 in HOLD.
REQ-028: out_avg SHALL always divide by N (shift by CW), including for flushed partial blocks.
REQ-029: cnt SHALL never exceed N; out_count = N for full blocks and equals the partial count for flushed blocks.

Reset
REQ-030: rst = 1 SHALL force ACCUM, acc = 0, cnt = 0, out_sum = 0, out_avg = 0, out_count = 0, out_valid = 0 and in_ready = 1 on the next edge.
REQ-031: rst SHALL take priority over in_valid, flush and out_ready in the same cycle.
REQ-032: A reset mid-block or during HOLD SHALL discard the partial or pending result.

Verification (W=6, N=4)
REQ-033: Full block: accept 10, 20, 30, 40 on consecutive cycles -> the next cycle shows out_valid=1, out_sum=100, out_avg=25, out_count=4, in_ready=0.
REQ-034: Maximum values: four samples of 63 -> out_sum=252, out_avg=63, out_count=4; no wrap occurs.
REQ-035: Backpressure: after a full block, hold out_ready=0 for 3 cycles while in_valid=1 -> outputs stay stable and no sample is accepted. Then assert out_ready=1 for 1 cycle -> the next cycle shows in_ready=1, and a new block of 1, 1, 1, 1 gives out_sum=4.
REQ-036: Flush: accept 5 and 7, then assert flush alone -> out_sum=12, out_count=2, out_avg=3. A second flush with an empty block produces no out_valid.
REQ-037: Simultaneous events: accept 5 and 7, then present sample 9 with flush in the same cycle -> out_sum=21, out_count=3, out_avg=5.
REQ-038: Reset mid-block: accept 10 and 20, assert rst for 1 cycle, then accept 1, 2, 3, 4 -> out_sum=10, out_count=4; the earlier samples are lost.
